// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state, entry and redirect-priority definitions for the fetch stage
package fetch_pkg;
  localparam int ENTRY_ADDR_W = 32;
  localparam int ENTRY_INSTR_W = 32;
  typedef enum logic {FETCH, HALTED} fetch_state_e;
  typedef enum logic [1:0] {SEL_BRANCH, SEL_JUMP_MEM, SEL_JUMP} redir_sel_e;
  typedef struct packed {
    logic [ENTRY_ADDR_W-1:0] pc;
    logic [ENTRY_INSTR_W-1:0] instr;
  } fetch_entry_t;
  function automatic redir_sel_e redirect_sel(input logic branch, input logic jump_mem);
    return branch ? SEL_BRANCH : jump_mem ? SEL_JUMP_MEM : SEL_JUMP;
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry synchronous FIFO with flush; push accepted when full only alongside a pop
// ports: i_push/i_pop/i_flush control, i_data in, o_data head, o_count occupancy, o_full/o_empty flags
module fetch_fifo #(
  parameter int W = 64,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic          i_flush,
  input  logic [W-1:0]  i_data,
  output logic [W-1:0]  o_data,
  output logic [CW-1:0] o_count,
  output logic          o_full,
  output logic          o_empty
);
  logic [W-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wr, r_rd;
  logic [CW-1:0] r_count;
  logic w_push, w_pop;
  assign o_full = r_count == CW'(DEPTH);
  assign o_empty = r_count == '0;
  assign w_pop = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);
  assign o_data = r_mem[r_rd];
  assign o_count = r_count;
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wr <= '0;
      r_rd <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + PW'(1);
      if (w_pop) r_rd <= r_rd + PW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end
  always_ff @(posedge clk) if (w_push) r_mem[r_wr] <= i_data;
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: decoupled fetch stage with credit-limited memory requests, prefetch buffer and prioritised redirects
// ports: branch/jump_mem/jump + targets redirect; halt stops issue; imem_req_*/imem_rsp_* memory side;
// instr_valid/ready/data/pc decode side; fetch_idle when halted with nothing in flight or buffered
module instr_fetch_unit import fetch_pkg::*; #(
  parameter int ADDR_W = 32,
  parameter int INSTR_W = 32,
  parameter int DEPTH = 4,
  parameter int PC_STEP = 1,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               branch,
  input  logic               jump_mem,
  input  logic               jump,
  input  logic [ADDR_W-1:0]  branch_target,
  input  logic [ADDR_W-1:0]  jump_mem_target,
  input  logic [ADDR_W-1:0]  jump_target,
  input  logic               halt,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [ADDR_W-1:0]  imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr_data,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               fetch_idle
);
  localparam int CW = $clog2(DEPTH) + 1;
  fetch_state_e r_state, w_next;
  redir_sel_e w_sel;
  logic [ADDR_W-1:0] r_pc, w_target, w_pcq_head;
  logic [CW-1:0] r_out, r_disc, w_cnt, w_pcq_cnt;
  logic [CW:0] w_used;
  logic [ADDR_W+INSTR_W-1:0] w_head;
  logic w_redirect, w_fire, w_keep, w_buf_empty, w_buf_full, w_pcq_full, w_pcq_empty, w_unused;
  assign w_redirect = branch | jump_mem | jump;
  assign w_sel = redirect_sel(branch, jump_mem);
  assign w_target = w_sel == SEL_BRANCH ? branch_target : w_sel == SEL_JUMP_MEM ? jump_mem_target : jump_target;
  // live in-flight responses plus buffered entries must never exceed the buffer, so every response has a slot
  assign w_used = {1'b0, r_out} - {1'b0, r_disc} + {1'b0, w_cnt};
  assign w_fire = imem_req_valid && imem_req_ready;
  assign w_keep = imem_rsp_valid && r_disc == '0;
  assign imem_req_addr = r_pc;
  assign {instr_pc, instr_data} = w_head;
  assign w_unused = ^{w_pcq_cnt, w_pcq_full, w_pcq_empty, w_buf_full};
  always_ff @(posedge clk) r_state <= rst ? FETCH : w_next;
  always_comb begin
    w_next = w_redirect ? FETCH : halt ? HALTED : FETCH;
    imem_req_valid = !rst && r_state == FETCH && !w_redirect && w_used < (CW+1)'(DEPTH);
    instr_valid = !rst && !w_buf_empty && !w_redirect;
    fetch_idle = !rst && r_state == HALTED && r_out == '0 && w_cnt == '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= RESET_PC;
      r_out <= '0;
      r_disc <= '0;
    end else begin
      r_pc <= w_redirect ? w_target : w_fire ? r_pc + ADDR_W'(PC_STEP) : r_pc;
      r_out <= r_out + CW'(w_fire) - CW'(imem_rsp_valid);
      // on redirect every response still owed (minus the one arriving now) belongs to the old path
      r_disc <= w_redirect ? r_out - CW'(imem_rsp_valid) : r_disc - CW'(imem_rsp_valid && r_disc != '0);
    end
  end
  fetch_fifo #(.W(ADDR_W), .DEPTH(DEPTH)) u_pcq (
    .clk(clk), .rst(rst), .i_push(w_fire), .i_pop(w_keep && !w_redirect), .i_flush(w_redirect),
    .i_data(r_pc), .o_data(w_pcq_head), .o_count(w_pcq_cnt), .o_full(w_pcq_full), .o_empty(w_pcq_empty)
  );
  fetch_fifo #(.W(ADDR_W + INSTR_W), .DEPTH(DEPTH)) u_buf (
    .clk(clk), .rst(rst), .i_push(w_keep), .i_pop(instr_valid && instr_ready), .i_flush(w_redirect),
    .i_data({w_pcq_head, imem_rsp_data}), .o_data(w_head), .o_count(w_cnt), .o_full(w_buf_full), .o_empty(w_buf_empty)
  );
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed self-checking bench with a fixed-latency in-order memory model
module tb_instr_fetch_unit;
  logic clk = 0, rst = 1, branch = 0, jump_mem = 0, jump = 0, halt = 0;
  logic [31:0] branch_target = 0, jump_mem_target = 0, jump_target = 0;
  logic imem_req_valid, imem_req_ready = 1, imem_rsp_valid;
  logic [31:0] imem_req_addr, imem_rsp_data, instr_data, instr_pc;
  logic instr_valid, instr_ready = 1, fetch_idle;
  int checks = 0, passed = 0, lat = 1, fires = 0, cyc = 0;
  logic [31:0] q_addr[$];
  int q_due[$];
  always #5 clk = ~clk;
  instr_fetch_unit dut (
    .clk(clk), .rst(rst), .branch(branch), .jump_mem(jump_mem), .jump(jump),
    .branch_target(branch_target), .jump_mem_target(jump_mem_target), .jump_target(jump_target),
    .halt(halt), .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_data(instr_data),
    .instr_pc(instr_pc), .fetch_idle(fetch_idle)
  );
  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'hC0DE0000;
  endfunction
  always @(posedge clk) begin
    if (rst) begin
      q_addr.delete();
      q_due.delete();
      imem_rsp_valid <= 0;
      fires <= 0;
    end else begin
      if (imem_req_valid && imem_req_ready) begin
        q_addr.push_back(imem_req_addr);
        q_due.push_back(cyc + lat - 1);
        fires <= fires + 1;
      end
      if (q_due.size() > 0 && q_due[0] <= cyc) begin
        imem_rsp_valid <= 1;
        imem_rsp_data <= mem(q_addr.pop_front());
        void'(q_due.pop_front());
      end else imem_rsp_valid <= 0;
    end
    cyc <= cyc + 1;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask
  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
    #1;
  endtask
  task automatic do_reset(input int l, input logic rdy);
    rst = 1;
    lat = l;
    instr_ready = rdy;
    tick(2);
    rst = 0;
    #1;
  endtask
  task automatic wait_valid(input string tag);
    int n = 0;
    while (!instr_valid && n < 30) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, instr_valid}, 32'd1);
  endtask
  initial begin
    logic [31:0] p0, p1;
    int got, f0;
    tick(2);
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_instr_valid", instr_valid, 0);
    chk("rst_fetch_idle", fetch_idle, 0);
    rst = 0;
    #1;
    chk("seq_addr0", imem_req_addr, 0);
    chk("seq_req_valid0", imem_req_valid, 1);
    tick();
    chk("seq_addr1", imem_req_addr, 1);
    chk("seq_no_valid_yet", instr_valid, 0);
    tick();
    chk("seq_first_valid", instr_valid, 1);
    chk("seq_pc0", instr_pc, 0);
    chk("seq_data0", instr_data, mem(0));
    chk("seq_addr2", imem_req_addr, 2);
    tick();
    chk("seq_pc1", instr_pc, 1);
    tick();
    chk("seq_pc2", instr_pc, 2);
    chk("seq_data2", instr_data, mem(2));
    do_reset(1, 0);
    tick(10);
    chk("full_fires", fires, 4);
    chk("full_req_valid", imem_req_valid, 0);
    chk("full_instr_valid", instr_valid, 1);
    chk("full_pc0", instr_pc, 0);
    chk("full_data0", instr_data, mem(0));
    instr_ready = 1;
    #1;
    chk("full_still_blocked", imem_req_valid, 0);
    tick();
    chk("resume_req_valid", imem_req_valid, 1);
    chk("resume_addr4", imem_req_addr, 4);
    chk("resume_pc1", instr_pc, 1);
    do_reset(4, 1);
    tick(3);
    chk("redir_outstanding", fires, 3);
    branch = 1;
    branch_target = 32'h40;
    #1;
    chk("redir_no_req", imem_req_valid, 0);
    chk("redir_no_instr", instr_valid, 0);
    tick();
    branch = 0;
    #1;
    chk("redir_req_valid", imem_req_valid, 1);
    chk("redir_addr", imem_req_addr, 32'h40);
    wait_valid("redir_wait");
    chk("redir_pc40", instr_pc, 32'h40);
    chk("redir_data40", instr_data, mem(32'h40));
    tick();
    chk("redir_pc41", instr_pc, 32'h41);
    tick();
    branch = 1;
    jump_mem = 1;
    jump = 1;
    branch_target = 32'h10;
    jump_mem_target = 32'h20;
    jump_target = 32'h30;
    #1;
    chk("prio_no_req", imem_req_valid, 0);
    chk("prio_no_instr", instr_valid, 0);
    tick();
    branch = 0;
    jump_mem = 0;
    jump = 0;
    #1;
    chk("prio_all_addr", imem_req_addr, 32'h10);
    chk("prio_all_valid", imem_req_valid, 1);
    tick();
    jump_mem = 1;
    jump = 1;
    #1;
    chk("prio_jm_no_req", imem_req_valid, 0);
    tick();
    jump_mem = 0;
    jump = 0;
    #1;
    chk("prio_jm_addr", imem_req_addr, 32'h20);
    tick();
    jump = 1;
    jump_target = 32'hFFFFFFFF;
    #1;
    tick();
    jump = 0;
    #1;
    chk("wrap_addr_max", imem_req_addr, 32'hFFFFFFFF);
    chk("wrap_valid_max", imem_req_valid, 1);
    tick();
    chk("wrap_addr_zero", imem_req_addr, 0);
    chk("wrap_valid_zero", imem_req_valid, 1);
    tick();
    jump = 1;
    jump_target = 32'h100;
    #1;
    tick();
    jump = 0;
    #1;
    chk("halt_addr100", imem_req_addr, 32'h100);
    tick();
    chk("halt_addr101", imem_req_addr, 32'h101);
    chk("halt_valid101", imem_req_valid, 1);
    halt = 1;
    tick();
    chk("halt_no_req", imem_req_valid, 0);
    chk("halt_not_idle", fetch_idle, 0);
    f0 = fires;
    got = 0;
    p0 = 0;
    p1 = 0;
    for (int i = 0; i < 12; i++) begin
      if (instr_valid && instr_ready) begin
        if (got == 0) p0 = instr_pc;
        if (got == 1) p1 = instr_pc;
        got++;
      end
      tick();
    end
    chk("halt_delivered", got, 2);
    chk("halt_pc_a", p0, 32'h100);
    chk("halt_pc_b", p1, 32'h101);
    chk("halt_no_new_fires", fires, f0);
    chk("halt_idle", fetch_idle, 1);
    chk("halt_still_no_req", imem_req_valid, 0);
    jump = 1;
    jump_target = 32'h80;
    #1;
    chk("halt_jump_no_req", imem_req_valid, 0);
    tick();
    jump = 0;
    halt = 0;
    #1;
    chk("unhalt_valid", imem_req_valid, 1);
    chk("unhalt_addr80", imem_req_addr, 32'h80);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
